i2c_txn_arbiter: RTL

//  Shares the single I2C transaction master between two requesters: port A (HTPA frame reader:

---
 rtl/i2c_txn_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one I2C transaction master between two requesters
// (A: HTPA frame reader, B: aux EEPROM/trim). Captures GO pulses, arbitrates
// round-robin, drives the master, routes the end-of-transaction ACK back and
// enforces a fixed idle gap between transactions.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   x_go/x_adr/x_rd/x_wdata/x_bytes  request pulse and fields (x = a, b)
//   x_ack, x_busy              per-port done pulse, pending-or-in-flight flag
//   m_go/m_adr/m_rd/m_wdata/m_bytes  start pulse and fields to the master
//   m_ack                      end-of-transaction pulse from the master
//   owner                      0=A, 1=B: port issued or in flight
//   overrun                    sticky: a GO was dropped because port was busy
//   err                        pulse with x_ack on a BUSY timeout abort
// Optional: define HTPA_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES.
module i2c_txn_arbiter #(
    parameter int unsigned GAP_CYCLES     = 12
`ifdef HTPA_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_go,
    input  logic [7:0]  a_adr,
    input  logic        a_rd,
    input  logic [7:0]  a_wdata,
    input  logic [15:0] a_bytes,
    output logic        a_ack,
    output logic        a_busy,
    input  logic        b_go,
    input  logic [7:0]  b_adr,
    input  logic        b_rd,
    input  logic [7:0]  b_wdata,
    input  logic [15:0] b_bytes,
    output logic        b_ack,
    output logic        b_busy,
    output logic        m_go,
    output logic [7:0]  m_adr,
    output logic        m_rd,
    output logic [7:0]  m_wdata,
    output logic [15:0] m_bytes,
    input  logic        m_ack,
    output logic        owner,
    output logic        overrun,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_GAP
    } state_t;

    // GAP_CYCLES=0 still spends one cycle in GAP.
    localparam logic [7:0] GAP_LAST =
        (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t      state_q;
    logic        pend_a_q, pend_b_q;
    logic        a_busy_q, b_busy_q;
    logic        last_q, owner_q;
    logic [7:0]  a_adr_q, a_wdata_q, b_adr_q, b_wdata_q;
    logic        a_rd_q, b_rd_q;
    logic [15:0] a_bytes_q, b_bytes_q;
    logic        m_go_q, m_rd_q;
    logic [7:0]  m_adr_q, m_wdata_q;
    logic [15:0] m_bytes_q;
    logic        a_ack_q, b_ack_q, overrun_q;
    logic [7:0]  gap_q;
    logic        win_b_d;

`ifdef HTPA_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q;
    logic        err_q;
`endif

    // B wins when it is the only requester, or on a tie when A went last.
    assign win_b_d = pend_b_q & (~pend_a_q | ~last_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pend_a_q  <= 1'b0;
            pend_b_q  <= 1'b0;
            a_busy_q  <= 1'b0;
            b_busy_q  <= 1'b0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            a_adr_q   <= 8'h00;
            a_wdata_q <= 8'h00;
            a_rd_q    <= 1'b0;
            a_bytes_q <= 16'd0;
            b_adr_q   <= 8'h00;
            b_wdata_q <= 8'h00;
            b_rd_q    <= 1'b0;
            b_bytes_q <= 16'd0;
            m_go_q    <= 1'b0;
            m_adr_q   <= 8'h01;
            m_rd_q    <= 1'b1;
            m_wdata_q <= 8'h00;
            m_bytes_q <= 16'd1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            overrun_q <= 1'b0;
            gap_q     <= 8'd0;
`ifdef HTPA_ARB_TIMEOUT_EN
            tmo_q     <= 16'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            m_go_q  <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
`ifdef HTPA_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (pend_a_q | pend_b_q) state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    m_go_q  <= 1'b1;
                    owner_q <= win_b_d;
                    last_q  <= win_b_d;
                    if (win_b_d) begin
                        m_adr_q   <= b_adr_q;
                        m_rd_q    <= b_rd_q;
                        m_wdata_q <= b_wdata_q;
                        m_bytes_q <= b_bytes_q;
                        pend_b_q  <= 1'b0;
                    end else begin
                        m_adr_q   <= a_adr_q;
                        m_rd_q    <= a_rd_q;
                        m_wdata_q <= a_wdata_q;
                        m_bytes_q <= a_bytes_q;
                        pend_a_q  <= 1'b0;
                    end
`ifdef HTPA_ARB_TIMEOUT_EN
                    tmo_q <= 16'd0;
`endif
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (m_ack) begin
                        if (owner_q) begin
                            b_ack_q  <= 1'b1;
                            b_busy_q <= 1'b0;
                        end else begin
                            a_ack_q  <= 1'b1;
                            a_busy_q <= 1'b0;
                        end
                        gap_q   <= 8'd0;
                        state_q <= S_GAP;
                    end
`ifdef HTPA_ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        if (owner_q) begin
                            b_ack_q  <= 1'b1;
                            b_busy_q <= 1'b0;
                        end else begin
                            a_ack_q  <= 1'b1;
                            a_busy_q <= 1'b0;
                        end
                        err_q   <= 1'b1;
                        gap_q   <= 8'd0;
                        state_q <= S_GAP;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
`endif
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) state_q <= S_IDLE;
                    else gap_q <= gap_q + 8'd1;
                end
                default: state_q <= S_IDLE;
            endcase
            // A busy port cannot be pending-cleared or acked this edge,
            // so capture never collides with the FSM updates above.
            if (a_go) begin
                if (a_busy_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    a_busy_q  <= 1'b1;
                    pend_a_q  <= 1'b1;
                    a_adr_q   <= a_adr;
                    a_rd_q    <= a_rd;
                    a_wdata_q <= a_wdata;
                    a_bytes_q <= a_bytes;
                end
            end
            if (b_go) begin
                if (b_busy_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    b_busy_q  <= 1'b1;
                    pend_b_q  <= 1'b1;
                    b_adr_q   <= b_adr;
                    b_rd_q    <= b_rd;
                    b_wdata_q <= b_wdata;
                    b_bytes_q <= b_bytes;
                end
            end
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_busy  = a_busy_q;
    assign b_busy  = b_busy_q;
    assign m_go    = m_go_q;
    assign m_adr   = m_adr_q;
    assign m_rd    = m_rd_q;
    assign m_wdata = m_wdata_q;
    assign m_bytes = m_bytes_q;
    assign owner   = owner_q;
    assign overrun = overrun_q;
`ifdef HTPA_ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule
